// File: rtl/tt_um_fan_ctrl.sv
// Fan controller: low-rate PI regulator on a 4-bit ADC/setpoint pair.
// It drives a PWM fan pin and a hex 7-segment digit from the saturated output u.
module tt_um_fan_ctrl #(
    parameter int CLK_FREQ  = 1000000,
    parameter int PID_FREQ  = 5,
    parameter int KP        = 8,
    parameter int KI        = 2,
    parameter int FRAC_BITS = 4,
    parameter int PWM_DIV   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int PID_DIV = CLK_FREQ / PID_FREQ - 1;
    localparam int DIV_W   = $clog2(PID_DIV + 1);
    localparam int PRE_W   = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic signed [11:0] KP_S  = 12'(KP);
    localparam logic signed [11:0] KI_S  = 12'(KI);
    localparam logic signed [11:0] I_MAX = 12'(15 << FRAC_BITS);

    logic [DIV_W-1:0]   div_q;
    logic               tick;
    logic [2:0]         vld_pipe;
    logic [3:0]         adc_q, set_q;
    logic signed [11:0] p_q, inext_q, integ_q, sum_q;
    logic [3:0]         u_q;
    logic [PRE_W-1:0]   pre_q;
    logic [3:0]         cnt_q;

    logic signed [4:0]  e;
    logic signed [11:0] e12, p_d, inext_d, iclamp, sum_d, sh;
    logic [3:0]         u_d;
    logic [6:0]         seg;
    logic               unused;

    assign unused = &{1'b0, ena, uio_in};
    assign tick   = (div_q == DIV_W'(PID_DIV));

    // Datapath: e from the sampled pair, then P/I terms, anti-windup clamp, output clamp.
    always_comb begin
        e       = 5'({1'b0, set_q}) - 5'({1'b0, adc_q});
        e12     = {{7{e[4]}}, e};
        p_d     = KP_S * e12;
        inext_d = integ_q + KI_S * e12;
        iclamp  = inext_q;
        if (inext_q < 12'sd0)
            iclamp = 12'sd0;
        else if (inext_q > I_MAX)
            iclamp = I_MAX;
        sum_d = p_q + iclamp;
        sh    = sum_q >>> FRAC_BITS;
        u_d   = sh[3:0];
        if (sh < 12'sd0)
            u_d = 4'd0;
        else if (sh > 12'sd15)
            u_d = 4'd15;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= '0;
            vld_pipe <= '0;
            adc_q    <= '0;
            set_q    <= '0;
            p_q      <= '0;
            inext_q  <= '0;
            integ_q  <= '0;
            sum_q    <= '0;
            u_q      <= '0;
            pre_q    <= '0;
            cnt_q    <= '0;
        end else begin
            div_q    <= tick ? '0 : div_q + 1'b1;
            vld_pipe <= {vld_pipe[1:0], tick};
            if (tick) begin
                adc_q <= ui_in[3:0];
                set_q <= ui_in[7:4];
            end
            if (vld_pipe[0]) begin
                p_q     <= p_d;
                inext_q <= inext_d;
            end
            if (vld_pipe[1]) begin
                integ_q <= iclamp;
                sum_q   <= sum_d;
            end
            if (vld_pipe[2])
                u_q <= u_d;
            if (pre_q == PRE_W'(PWM_DIV - 1)) begin
                pre_q <= '0;
                cnt_q <= cnt_q + 1'b1;
            end else begin
                pre_q <= pre_q + 1'b1;
            end
        end
    end

    always_comb begin
        seg = 7'h3F;
        case (u_q)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h3F;
        endcase
    end

    // PWM compares against the live u, so a new output takes effect mid-period.
    assign uo_out  = {(cnt_q < u_q), seg};
    assign uio_out = {4'b0000, u_q};
    assign uio_oe  = 8'h1F;

endmodule

// File: tb/tb_tt_um_fan_ctrl.sv
// Directed bench for tt_um_fan_ctrl with a shortened 100-clock control period.
module tb_tt_um_fan_ctrl;
    localparam int N = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    tt_um_fan_ctrl #(.CLK_FREQ(100), .PID_FREQ(1)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; tick edge n lands on cyc == N*n.
    int cyc;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit         rst;
        logic [3:0] adc;
        logic [3:0] set;
        logic [3:0] u;
    } vec_t;
    vec_t vt[17];

    logic [6:0] seg_tab[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int t);
        int g = 0;
        while (cyc != t) begin
            @(negedge clk);
            g++;
            if (g > 1000) begin
                $display("FAIL wait_cyc: cyc %0d never reached %0d", cyc, t);
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
                $fatal(1);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_uio_out", uio_out, 8'h00);
        chk("rst_uio_oe", uio_oe, 8'h1F);
        chk("rst_uo_out", uo_out, 8'h3F);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pwm_count(output int h);
        h = 0;
        repeat (32) begin
            if (uo_out[7]) h++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n, h, x1, x2, a;
        logic [3:0] prev, u;

        vt[0]  = '{1'b1, 4'd7, 4'd5,  4'd0};
        vt[1]  = '{1'b0, 4'd7, 4'd5,  4'd0};
        vt[2]  = '{1'b0, 4'd7, 4'd5,  4'd0};
        vt[3]  = '{1'b0, 4'd7, 4'd5,  4'd0};
        vt[4]  = '{1'b0, 4'd7, 4'd5,  4'd0};
        vt[5]  = '{1'b0, 4'd0, 4'd15, 4'd9};
        vt[6]  = '{1'b0, 4'd0, 4'd15, 4'd11};
        vt[7]  = '{1'b0, 4'd0, 4'd15, 4'd13};
        vt[8]  = '{1'b0, 4'd0, 4'd15, 4'd15};
        vt[9]  = '{1'b0, 4'd0, 4'd15, 4'd15};
        vt[10] = '{1'b1, 4'd0, 4'd8,  4'd5};
        vt[11] = '{1'b0, 4'd0, 4'd8,  4'd6};
        vt[12] = '{1'b0, 4'd0, 4'd0,  4'd2};
        vt[13] = '{1'b0, 4'd15, 4'd0, 4'd0};
        vt[14] = '{1'b0, 4'd5, 4'd5,  4'd0};
        vt[15] = '{1'b0, 4'd0, 4'd2,  4'd1};
        vt[16] = '{1'b0, 4'd3, 4'd4,  4'd1};

        // Reset state, then a full PWM period with u = 0.
        do_reset();
        pwm_count(h);
        chk("pwm_after_rst", h, 0);

        // Table: junk on ui_in between ticks, real pair just before the tick.
        n = 0;
        prev = 4'd0;
        for (int k = 0; k < 17; k++) begin
            if (vt[k].rst) begin
                do_reset();
                n = 0;
                prev = 4'd0;
            end
            n++;
            ui_in = 8'($urandom);
            wait_cyc(N * n - 10);
            ui_in = {vt[k].set, vt[k].adc};
            wait_cyc(N * n + 2);
            chk($sformatf("v%0d_latency", k), uio_out, {4'b0, prev});
            wait_cyc(N * n + 3);
            chk($sformatf("v%0d_u", k), uio_out, {4'b0, vt[k].u});
            chk($sformatf("v%0d_seg", k), uo_out[6:0], seg_tab[vt[k].u]);
            pwm_count(h);
            chk($sformatf("v%0d_pwm_high", k), h, 2 * vt[k].u);
            prev = vt[k].u;
        end

        // Reset between tick and output stage discards the in-flight result.
        do_reset();
        ui_in = {4'd15, 4'd0};
        wait_cyc(N + 3);
        chk("mid_first_u", uio_out, 8'd9);
        wait_cyc(2 * N + 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_uio", uio_out, 8'h00);
        chk("mid_rst_seg", uo_out, 8'h3F);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(4);
        chk("mid_no_update", uio_out, 8'h00);
        wait_cyc(N + 2);
        chk("mid_div_restart_pre", uio_out, 8'h00);
        wait_cyc(N + 3);
        chk("mid_div_restart_u", uio_out, 8'd9);

        // Closed loop: two cascaded first-order lags (x16 scale), DC gain 1.
        do_reset();
        x1 = 160;
        x2 = 160;
        a  = 10;
        for (int t = 1; t <= 300; t++) begin
            ui_in = {4'd2, 4'(a)};
            wait_cyc(N * t + 3);
            u = uio_out[3:0];
            if (t == 1)  chk("loop_first_u", u, 0);
            if (t > 290) chk($sformatf("loop_settle_t%0d", t), u, 2);
            x1 = x1 + (16 * int'(u) - x1) / 4;
            x2 = x2 + (x1 - x2) / 4;
            a  = (x2 + 8) / 16;
            if (a < 0)  a = 0;
            if (a > 15) a = 15;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
